// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the multi-cycle CPU controller.
//   - state_t : 5-bit FSM state codes (also exported on the debug state port)
//   - opcode / op field constants of the 16-bit instruction word
//   - nsel / vsel / pcsel select codes
//   - ctrl_t  : bundle of datapath/memory control strobes
//   - branch_taken(): condition evaluation against {Z,N,V}
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST   = 5'd0,
    S_IF1   = 5'd1,
    S_IF2   = 5'd2,
    S_DEC   = 5'd3,
    S_WIMM  = 5'd4,
    S_RDA   = 5'd5,
    S_RDB   = 5'd6,
    S_EXE   = 5'd7,
    S_WB    = 5'd8,
    S_ADDR  = 5'd9,
    S_MADDR = 5'd10,
    S_LD1   = 5'd11,
    S_LD2   = 5'd12,
    S_STB   = 5'd13,
    S_STC   = 5'd14,
    S_ST    = 5'd15,
    S_BR    = 5'd16,
    S_HALT  = 5'd17
  } state_t;

  localparam logic [2:0] OPC_BR   = 3'b001;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_BCOND   = 2'b00;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  localparam logic [1:0] PCSEL_INC  = 2'b00;
  localparam logic [1:0] PCSEL_ZERO = 2'b01;
  localparam logic [1:0] PCSEL_BR   = 2'b10;

  typedef struct packed {
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic [1:0] pcsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic       bsel;
    logic       loadpc;
    logic       msel;
    logic       load_addr;
    logic       mem_req;
    logic       mem_we;
    logic       loadir;
  } ctrl_t;

  // status = {Z,N,V}
  function automatic logic branch_taken(input logic [2:0] cond, input logic [2:0] status);
    logic z, n, v;
    z = status[2];
    n = status[1];
    v = status[0];
    case (cond)
      3'b000:  return 1'b1;
      3'b001:  return z;
      3'b010:  return !z;
      3'b011:  return n ^ v;
      3'b100:  return (n ^ v) | z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: bundle between the controller and the rest of the core.
//   Decode inputs : opcode[2:0], op[1:0], cond[2:0], status[2:0] {Z,N,V}
//   Memory        : mem_ready (in), mem_req, mem_we, msel, load_addr (out)
//   Datapath      : nsel, vsel, loada/b/c, loads, write, asel, bsel
//   PC / IR       : loadpc, pcsel, loadir
//   Status        : halted, bus_err, state[4:0]
// modport master = controller side, modport slave = datapath/memory side.
interface cpu_ctrl_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic [2:0] status;
  logic       mem_ready;

  logic [1:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       write;
  logic       asel;
  logic       bsel;
  logic       loadpc;
  logic [1:0] pcsel;
  logic       msel;
  logic       load_addr;
  logic       mem_req;
  logic       mem_we;
  logic       loadir;
  logic       halted;
  logic       bus_err;
  logic [4:0] state;

  modport master (
    input  opcode, op, cond, status, mem_ready,
    output nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
           loadpc, pcsel, msel, load_addr, mem_req, mem_we, loadir,
           halted, bus_err, state
  );

  modport slave (
    output opcode, op, cond, status, mem_ready,
    input  nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
           loadpc, pcsel, msel, load_addr, mem_req, mem_we, loadir,
           halted, bus_err, state
  );
endinterface

// File: rtl/cpu_mem_wait_timer.sv
// cpu_mem_wait_timer: counts memory wait cycles for the controller.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (asserted on every state change, so the
//                count starts at 0 on entry to a wait state)
//   waiting    : in a wait state with mem_ready low; advances the count
//   expired    : count has reached TIMEOUT (never asserted when TIMEOUT=0)
// CNT_W must satisfy 2**CNT_W > TIMEOUT.
module cpu_mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (waiting) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: Moore multi-cycle controller for the 16-bit RISC core.
// Fetches through a ready-handshaked memory port, decodes {opcode,op} and
// sequences register-file/ALU strobes; LDR/STR, HALT and bus timeout.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : cpu_ctrl_if.master (decode inputs, memory handshake,
//                datapath/PC/IR strobes, halted, bus_err, debug state)
// Parameters:
//   TIMEOUT : max memory wait cycles before bus_err (0 disables)
//   CNT_W   : wait counter width, 2**CNT_W > TIMEOUT
// Build option:
//   CPU_CTRL_BRANCH_EN : enables conditional branches (opcode 001, op 00);
//                        when undefined that code is a NOP.
module cpu_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  cpu_ctrl_if.master bus
);
  import cpu_ctrl_pkg::*;

  state_t r_state;
  state_t w_next;
  logic   r_bus_err;
  logic   w_wait_state;
  logic   w_expired;
  logic   w_timeout;
  ctrl_t  w_ctrl;

  assign w_wait_state = (r_state == S_IF1) || (r_state == S_LD1) || (r_state == S_ST);
  // mem_ready in the expiry cycle wins over the timeout
  assign w_timeout    = w_wait_state && !bus.mem_ready && w_expired;

  cpu_mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_next != r_state),
    .waiting (w_wait_state && !bus.mem_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RST;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:  w_next = S_IF1;
      S_IF1: begin
        if (bus.mem_ready)  w_next = S_IF2;
        else if (w_expired) w_next = S_HALT;
      end
      S_IF2:  w_next = S_DEC;
      S_DEC: begin
        case (bus.opcode)
          OPC_MOV: begin
            if (bus.op == OP_MOV_IMM)      w_next = S_WIMM;
            else if (bus.op == OP_MOV_REG) w_next = S_RDB;
            else                           w_next = S_IF1;
          end
          OPC_ALU:  w_next = (bus.op == OP_MVN) ? S_RDB : S_RDA;
          OPC_LDR:  w_next = (bus.op == OP_MEM) ? S_RDA : S_IF1;
          OPC_STR:  w_next = (bus.op == OP_MEM) ? S_RDA : S_IF1;
          OPC_HALT: w_next = S_HALT;
`ifdef CPU_CTRL_BRANCH_EN
          OPC_BR:   w_next = (bus.op == OP_BCOND) ? S_BR : S_IF1;
`endif
          default:  w_next = S_IF1;
        endcase
      end
      S_WIMM: w_next = S_IF1;
      S_RDA:  w_next = ((bus.opcode == OPC_LDR) || (bus.opcode == OPC_STR)) ? S_ADDR : S_RDB;
      S_RDB:  w_next = S_EXE;
      S_EXE:  w_next = ((bus.opcode == OPC_ALU) && (bus.op == OP_CMP)) ? S_IF1 : S_WB;
      S_WB:   w_next = S_IF1;
      S_ADDR: w_next = S_MADDR;
      S_MADDR: w_next = (bus.opcode == OPC_LDR) ? S_LD1 : S_STB;
      S_LD1: begin
        if (bus.mem_ready)  w_next = S_LD2;
        else if (w_expired) w_next = S_HALT;
      end
      S_LD2:  w_next = S_IF1;
      S_STB:  w_next = S_STC;
      S_STC:  w_next = S_ST;
      S_ST: begin
        if (bus.mem_ready)  w_next = S_IF1;
        else if (w_expired) w_next = S_HALT;
      end
      S_BR:   w_next = S_IF1;
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_RST: begin
        w_ctrl.loadpc = 1'b1;
        w_ctrl.pcsel  = PCSEL_ZERO;
      end
      S_IF1: w_ctrl.mem_req = 1'b1;
      S_IF2: begin
        w_ctrl.loadir = 1'b1;
        w_ctrl.loadpc = 1'b1;
        w_ctrl.pcsel  = PCSEL_INC;
      end
      S_WIMM: begin
        w_ctrl.nsel  = NSEL_RN;
        w_ctrl.vsel  = VSEL_IMM;
        w_ctrl.write = 1'b1;
      end
      S_RDA: begin
        w_ctrl.nsel  = NSEL_RN;
        w_ctrl.loada = 1'b1;
      end
      S_RDB: begin
        w_ctrl.nsel  = NSEL_RM;
        w_ctrl.loadb = 1'b1;
      end
      S_EXE: begin
        // MOV-reg and MVN pass B through with a zero A operand
        w_ctrl.asel = (bus.opcode == OPC_MOV) ||
                      ((bus.opcode == OPC_ALU) && (bus.op == OP_MVN));
        if ((bus.opcode == OPC_ALU) && (bus.op == OP_CMP)) w_ctrl.loads = 1'b1;
        else                                               w_ctrl.loadc = 1'b1;
      end
      S_WB: begin
        w_ctrl.nsel  = NSEL_RD;
        w_ctrl.vsel  = VSEL_C;
        w_ctrl.write = 1'b1;
      end
      S_ADDR: begin
        w_ctrl.bsel  = 1'b1;
        w_ctrl.loadc = 1'b1;
      end
      S_MADDR: w_ctrl.load_addr = 1'b1;
      S_LD1: begin
        w_ctrl.msel    = 1'b1;
        w_ctrl.mem_req = 1'b1;
      end
      S_LD2: begin
        w_ctrl.nsel  = NSEL_RD;
        w_ctrl.vsel  = VSEL_MDATA;
        w_ctrl.write = 1'b1;
      end
      S_STB: begin
        w_ctrl.nsel  = NSEL_RD;
        w_ctrl.loadb = 1'b1;
      end
      S_STC: begin
        w_ctrl.asel  = 1'b1;
        w_ctrl.loadc = 1'b1;
      end
      S_ST: begin
        w_ctrl.msel    = 1'b1;
        w_ctrl.mem_req = 1'b1;
        w_ctrl.mem_we  = 1'b1;
      end
`ifdef CPU_CTRL_BRANCH_EN
      S_BR: begin
        if (branch_taken(bus.cond, bus.status)) begin
          w_ctrl.loadpc = 1'b1;
          w_ctrl.pcsel  = PCSEL_BR;
        end
      end
`endif
      default: ;
    endcase
  end

`ifndef CPU_CTRL_BRANCH_EN
  logic w_unused_branch;
  assign w_unused_branch = ^{bus.cond, bus.status};
`endif

  assign bus.nsel      = w_ctrl.nsel;
  assign bus.vsel      = w_ctrl.vsel;
  assign bus.pcsel     = w_ctrl.pcsel;
  assign bus.loada     = w_ctrl.loada;
  assign bus.loadb     = w_ctrl.loadb;
  assign bus.loadc     = w_ctrl.loadc;
  assign bus.loads     = w_ctrl.loads;
  assign bus.write     = w_ctrl.write;
  assign bus.asel      = w_ctrl.asel;
  assign bus.bsel      = w_ctrl.bsel;
  assign bus.loadpc    = w_ctrl.loadpc;
  assign bus.msel      = w_ctrl.msel;
  assign bus.load_addr = w_ctrl.load_addr;
  assign bus.mem_req   = w_ctrl.mem_req;
  assign bus.mem_we    = w_ctrl.mem_we;
  assign bus.loadir    = w_ctrl.loadir;
  assign bus.halted    = (r_state == S_HALT);
  assign bus.bus_err   = r_bus_err;
  assign bus.state     = r_state;

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control state machine for the 16-bit RISC core: fetches instructions through a ready-handshaked memory port, decodes `opcode`/`op` from the instruction register, and sequences the register-file/ALU datapath control strobes. It replaces the fixed-latency controller with one that tolerates variable memory latency, adds LDR/STR, HALT and a bus-timeout, and optionally supports conditional branches. It sits between the instruction register and decoder on one side, and the datapath, PC counter and RAM on the other.

## Interface
- `TIMEOUT`, default 15: maximum memory wait cycles before `bus_err`. A value of 0 disables the timeout.
- `CNT_W`, default 4: width of the wait counter. It must satisfy 2^CNT_W > TIMEOUT.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `opcode`, in, 3: instruction bits [15:13] from the IR.
- `op`, in, 2: instruction bits [12:11].
- `cond`, in, 3: instruction bits [10:8]. Used only for branches.
- `status`, in, 3: datapath flags {Z,N,V}.
- `mem_ready`, in, 1: memory accepted or completed the current `mem_req`.
- `nsel`, out, 2: register select. 00 = Rn, 01 = Rd, 10 = Rm.
- `vsel`, out, 2: writeback source. 00 = mdata, 01 = sximm8, 10 = PC, 11 = C.
- `loada`, `loadb`, `loadc`, `loads`, `write`, out, 1 each: datapath load and write strobes.
- `asel`, `bsel`, out, 1 each:
  - `asel` = 1 selects 0 as the A operand.
  - `bsel` = 1 selects sximm5 as the B operand.
- `loadpc`, out, 1: PC load strobe.
- `pcsel`, out, 2: PC next value. 00 = PC+1, 01 = 0, 10 = PC+sximm8.
- `msel`, out, 1: address source. 0 = PC, 1 = data-address register.
- `load_addr`, out, 1: load the data-address register from C.
- `mem_req`, `mem_we`, out, 1 each: memory request and write enable.
- `loadir`, out, 1: instruction register load.
- `halted`, out, 1: high while in HALT.
- `bus_err`, out, 1: sticky timeout flag.
- `state`, out, 5: current state code, for debug.

## Operation
- The machine is Moore: outputs are decoded from `state` only. Every unlisted output is 0 in every state.
- **RST:** `loadpc`=1, `pcsel`=01. Goes to IF1 when `reset`=0.
- **IF1:** `msel`=0, `mem_req`=1. Holds until `mem_ready`=1, then goes to IF2.
- **IF2:** `loadir`=1, `loadpc`=1, `pcsel`=00. Goes to DEC.
- **DEC:** branches on {opcode,op}:
  - 110,10 → WIMM
  - 110,00 → RDB
  - 101,11 → RDB
  - 101,other → RDA
  - 011,00 → RDA
  - 100,00 → RDA
  - 111,xx → HALT
  - 001,00 → BR (only when CPU_CTRL_BRANCH_EN is defined)
  - any other code is a NOP → IF1
- **WIMM:** `nsel`=Rn, `vsel`=01, `write`. Goes to IF1.
- **RDA:** `nsel`=Rn, `loada`. Goes to ADDR for LDR/STR, otherwise to RDB.
- **RDB:** `nsel`=Rm, `loadb`. Goes to EXE.
- **EXE:**
  - `asel`=1 for MOV-reg and MVN; `bsel`=0.
  - CMP: `loads`=1, goes to IF1.
  - All others: `loadc`=1, goes to WB.
- **WB:** `nsel`=Rd, `vsel`=11, `write`. Goes to IF1.
- **ADDR:** `asel`=0, `bsel`=1, `loadc`. Goes to MADDR.
- **MADDR:** `load_addr`. Goes to LD1 (LDR) or STB (STR).
- **LD1:** `msel`=1, `mem_req`. Holds until `mem_ready`, then goes to LD2.
- **LD2:** `nsel`=Rd, `vsel`=00, `write`. Goes to IF1. Memory holds mdata stable after ready.
- **STB:** `nsel`=Rd, `loadb`. Goes to STC.
- **STC:** `asel`=1, `loadc`. Goes to ST.
- **ST:** `msel`=1, `mem_req`, `mem_we`. Holds until `mem_ready`, then goes to IF1.
- **BR:** `loadpc`=1 with `pcsel`=10 if the branch is taken, otherwise no strobe. Goes to IF1.
  - Conditions: 000 always; 001 Z; 010 !Z; 011 N≠V; 100 (N≠V)|Z.
  - Other codes are never taken.
- **HALT:** `halted`=1. Stays until `reset`.
- **Timeout:** the wait counter clears on entry to IF1, LD1 or ST. It increments on each cycle in one of those states with `mem_ready`=0.
  - When the count equals TIMEOUT and `mem_ready`=0, the next state is HALT and `bus_err` is set.
  - `mem_ready`=1 in the same cycle wins over the timeout.

## Timing
- **Reset:** the cycle after a `reset` edge, the state is RST.
  - Outputs: `loadpc`=1, `pcsel`=01, `bus_err`=0, `halted`=0, all others 0.
  - Reset mid-instruction or mid-wait aborts immediately. A write that was in progress is dropped.
- **Cycle counts with zero-wait memory** (`mem_ready` high in the request cycle):
  - MOV-imm: 4
  - MOV-reg, MVN, CMP: 6
  - ADD, AND: 7
  - LDR: 8
  - STR: 9
  - Branch: 4
  - NOP: 3
- Each memory wait cycle adds 1.
- `mem_req` is held continuously from state entry until the cycle in which `mem_ready`=1.

## Configuration
- **CPU_CTRL_BRANCH_EN defined:** opcode 001 / op 00 enters BR and `pcsel`=10 can be generated.
- **CPU_CTRL_BRANCH_EN undefined:** opcode 001 decodes as a NOP, BR is unreachable, and `pcsel` is never 10. `cond` and `status` are unused.

## Structure
- **Package `cpu_ctrl_pkg`** holds:
  - the state enum (5-bit codes)
  - opcode constants MOV/ALU/STR/LDR/HALT/BR
  - op constants ADD/CMP/AND/MVN
  - nsel, vsel and pcsel codes
- **Sub-module `cpu_mem_wait_timer`** holds the wait counter and the TIMEOUT compare. It takes `clk`, `reset`, `clear`, `waiting`; it outputs `expired`.

## Test plan
- Reset → RST with `loadpc`=1 and `pcsel`=01. Release reset → IF1 with `mem_req`=1 and `msel`=0.
- MOV R0,#5 with zero-wait memory → `write`=1, `nsel`=00, `vsel`=01 in cycle 4, then back to IF1.
- ADD R2,R0,R1 with a 2-wait fetch → 9 cycles total; `loadc` in EXE; `write` with `vsel`=11 and `nsel`=01 in WB.
- `mem_ready` held low in LD1 with TIMEOUT=3 → HALT after 4 wait cycles, `bus_err`=1 and `halted`=1, both held until reset.
- STR with zero-wait memory → ST has `mem_we`=1 and `msel`=1 for one cycle. Assert `reset` during STC → RST next cycle and `mem_we` never asserts.
- With CPU_CTRL_BRANCH_EN:
  - BEQ with Z=1 → `loadpc`=1, `pcsel`=10 in BR.
  - BEQ with Z=0 → no `loadpc`.
  - Without the macro, the same word is a 3-cycle NOP.
